load_store_unit: RTL and testbench

//  Sits between the core datapath (ALU address + rs2 data + funct3) and the word-wide data

---
 rtl/load_store_unit.sv | 188 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit
//   RV32I load/store unit between the core datapath and a word-wide data memory
//   with asynchronous read, synchronous write and no byte enables.
//   Sub-word stores are performed as read-modify-write. Loads are extracted from
//   the read word and then sign- or zero-extended. Misaligned, out-of-range and
//   illegal requests return rsp_err and never touch memory.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   req_valid/ready   request handshake (ready only while idle)
//   req_we            1 = store, 0 = load
//   req_funct3        RV32I width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   req_addr          byte address
//   req_wdata         store data (rs2)
//   rsp_valid/ready   response handshake (response held until accepted)
//   rsp_rdata         load result (0 for stores and errors)
//   rsp_err           misaligned / out-of-range / illegal funct3
//   mem_A             word address to data memory
//   mem_Data          write data to data memory
//   mem_W_en          write enable to data memory (one cycle per store)
//   mem_RD            asynchronous read data from data memory
`timescale 1ns/1ps
module load_store_unit #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_A,
  output logic [31:0]       mem_Data,
  output logic              mem_W_en,
  input  logic [31:0]       mem_RD
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_RESP
  } state_t;

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [ADDR_W+1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         word_q, word_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;

  logic                req_illegal;
  logic                req_misaligned;
  logic                req_out_of_range;
  logic                req_error;

  logic [4:0]          lane_shift;
  logic [31:0]         rd_shifted;
  logic [31:0]         load_value;
  logic [31:0]         lane_mask;
  logic [31:0]         merged_word;

  // Request classification on the live request inputs (used only in IDLE).
  always_comb begin
    req_illegal      = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11)
                       || (req_we && req_funct3[2]);
    req_misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0])
                       || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    req_out_of_range = |req_addr[31:ADDR_W+2];
    req_error        = req_illegal || req_misaligned || req_out_of_range;
  end

  // Byte offset of the addressed lane, in bits.
  assign lane_shift = {addr_q[1:0], 3'b000};

  // Load extraction: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    rd_shifted = mem_RD >> lane_shift;
    load_value = '0;
    unique case (funct3_q)
      3'b000:  load_value = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
      3'b001:  load_value = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
      3'b010:  load_value = rd_shifted;
      3'b100:  load_value = {24'h000000, rd_shifted[7:0]};
      3'b101:  load_value = {16'h0000, rd_shifted[15:0]};
      default: load_value = '0;
    endcase
  end

  // Store merge: replace only the addressed lane of the previously read word.
  always_comb begin
    lane_mask = '1;
    unique case (funct3_q[1:0])
      2'b00:   lane_mask = 32'h0000_00FF << lane_shift;
      2'b01:   lane_mask = 32'h0000_FFFF << lane_shift;
      default: lane_mask = '1;
    endcase
    merged_word = (word_q & ~lane_mask) | ((wdata_q << lane_shift) & lane_mask);
  end

  // Next-state and datapath next values.
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    word_d   = word_q;
    rdata_d  = rdata_q;
    err_d    = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr[ADDR_W+1:0];
          wdata_d  = req_wdata;
          rdata_d  = '0;
          err_d    = req_error;
          state_d  = req_error ? S_RESP : S_READ;
        end
      end
      S_READ: begin
        word_d = mem_RD;
        if (we_q) begin
          state_d = S_WRITE;
        end else begin
          rdata_d = load_value;
          state_d = S_RESP;
        end
      end
      S_WRITE: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      word_q   <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      word_q   <= word_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Write enable is decoded from the state register alone, so an asynchronous
  // reset during WRITE removes it immediately. mem_Data is a pure function of
  // registers that all reset to zero, so it reads 0 out of reset.
  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign mem_A     = addr_q[ADDR_W+1:2];
  assign mem_W_en  = (state_q == S_WRITE);
  assign mem_Data  = merged_word;

endmodule

// File: tb/tb_load_store_unit.sv
`timescale 1ns/1ps
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [9:0]  mem_A;
  logic [31:0] mem_Data;
  logic        mem_W_en;
  logic [31:0] mem_RD;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_A      (mem_A),
    .mem_Data   (mem_Data),
    .mem_W_en   (mem_W_en),
    .mem_RD     (mem_RD)
  );

  // Data memory: async read, sync write, plus a backdoor write port for preload.
  logic [31:0] mem [0:1023];
  logic        bd_we = 1'b0;
  logic [9:0]  bd_a  = '0;
  logic [31:0] bd_d  = '0;
  int          wen_cnt = 0;

  assign mem_RD = mem[mem_A];

  always @(posedge clk) begin
    if (bd_we) mem[bd_a] <= bd_d;
    else if (mem_W_en) mem[mem_A] <= mem_Data;
    if (mem_W_en) wen_cnt <= wen_cnt + 1;
  end

  // Reference memory, kept as words but accessed byte by byte by the model.
  logic [31:0] refmem [0:1023];

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Behavioural model: RV32I semantics on a byte-addressed view of refmem.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd,
                       output logic err, output int lat);
    int unsigned size;
    logic [31:0] v;
    logic [31:0] ba;
    rd   = '0;
    err  = 1'b0;
    size = 1 << f3[1:0];
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 || (we && f3 >= 3'd4)) err = 1'b1;
    else if ((a % size) != 0) err = 1'b1;
    else if (a >= 32'd4096) err = 1'b1;
    if (err) begin
      lat = 1;
    end else if (we) begin
      lat = 3;
      for (int unsigned i = 0; i < size; i++) begin
        ba = a + i;
        refmem[ba >> 2][8*ba[1:0] +: 8] = wd[8*i +: 8];
      end
    end else begin
      lat = 2;
      v = '0;
      for (int unsigned i = 0; i < size; i++) begin
        ba = a + i;
        v[8*i +: 8] = refmem[ba >> 2][8*ba[1:0] +: 8];
      end
      if (!f3[2] && size < 4 && v[8*size-1])
        v = v | ~((32'd1 << (8*size)) - 32'd1);
      rd = v;
    end
  endtask

  task automatic bd_write(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_a = a; bd_d = d;
    @(posedge clk); #1;
    bd_we = 1'b0;
    refmem[a] = d;
  endtask

  // One complete transaction with bounded waits; lat counts edges from acceptance.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic e, output int lat, output int wens);
    int w0;
    int n;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    w0 = wen_cnt;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = rsp_rdata;
    e  = rsp_err;
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    wens = wen_cnt - w0;
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t tv [19];

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd, erd, rd0;
    logic        e, ee;
    int          lat, elat, wens;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] a, wd;
    int unsigned r;

    tv[0]  = '{1'b0, 3'b000, 32'h16,   32'h0,        32'hFFFFFF99, 1'b0, 2};
    tv[1]  = '{1'b0, 3'b100, 32'h16,   32'h0,        32'h00000099, 1'b0, 2};
    tv[2]  = '{1'b0, 3'b001, 32'h16,   32'h0,        32'hFFFF8899, 1'b0, 2};
    tv[3]  = '{1'b0, 3'b101, 32'h14,   32'h0,        32'h0000AABB, 1'b0, 2};
    tv[4]  = '{1'b0, 3'b010, 32'h14,   32'h0,        32'h8899AABB, 1'b0, 2};
    tv[5]  = '{1'b1, 3'b001, 32'h16,   32'h00001234, 32'h0,        1'b0, 3};
    tv[6]  = '{1'b0, 3'b010, 32'h14,   32'h0,        32'h1234AABB, 1'b0, 2};
    tv[7]  = '{1'b1, 3'b000, 32'h15,   32'hFFFFFF77, 32'h0,        1'b0, 3};
    tv[8]  = '{1'b0, 3'b010, 32'h14,   32'h0,        32'h123477BB, 1'b0, 2};
    tv[9]  = '{1'b1, 3'b010, 32'hFFC,  32'hDEADBEEF, 32'h0,        1'b0, 3};
    tv[10] = '{1'b0, 3'b010, 32'hFFC,  32'h0,        32'hDEADBEEF, 1'b0, 2};
    tv[11] = '{1'b1, 3'b010, 32'h1000, 32'h11111111, 32'h0,        1'b1, 1};
    tv[12] = '{1'b0, 3'b010, 32'h02,   32'h0,        32'h0,        1'b1, 1};
    tv[13] = '{1'b1, 3'b001, 32'h05,   32'h00005555, 32'h0,        1'b1, 1};
    tv[14] = '{1'b0, 3'b011, 32'h14,   32'h0,        32'h0,        1'b1, 1};
    tv[15] = '{1'b1, 3'b100, 32'h14,   32'h000000AA, 32'h0,        1'b1, 1};
    tv[16] = '{1'b0, 3'b010, 32'h14,   32'h0,        32'h123477BB, 1'b0, 2};
    tv[17] = '{1'b0, 3'b000, 32'h17,   32'h0,        32'h00000012, 1'b0, 2};
    tv[18] = '{1'b0, 3'b001, 32'h16,   32'h0,        32'h00001234, 1'b0, 2};

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;

    #2;
    chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("reset_rsp_rdata", rsp_rdata, 32'h0);
    chk("reset_rsp_err",   {31'b0, rsp_err}, 32'h0);
    chk("reset_mem_W_en",  {31'b0, mem_W_en}, 32'h0);
    chk("reset_mem_A",     {22'b0, mem_A}, 32'h0);
    chk("reset_mem_Data",  mem_Data, 32'h0);

    for (int i = 0; i < 1024; i++) bd_write(10'(i), $urandom);
    bd_write(10'd5, 32'h8899AABB);

    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_req_ready", {31'b0, req_ready}, 32'h1);

    // Directed vectors
    for (int i = 0; i < 19; i++) begin
      do_req(tv[i].we, tv[i].f3, tv[i].addr, tv[i].wdata, rd, e, lat, wens);
      model(tv[i].we, tv[i].f3, tv[i].addr, tv[i].wdata, erd, ee, elat);
      chk($sformatf("vec%0d_rdata", i), rd, tv[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), {31'b0, e}, {31'b0, tv[i].exp_err});
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(tv[i].exp_lat));
      chk($sformatf("vec%0d_wen_pulses", i), 32'(wens),
          (tv[i].we && !tv[i].exp_err) ? 32'd1 : 32'd0);
    end
    chk("mem1023_after_sw", mem[1023], 32'hDEADBEEF);
    chk("mem5_after_errors", mem[5], 32'h123477BB);

    // Response back-pressure: outputs held, no new request accepted
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h14;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rd0 = rsp_rdata;
    chk("bp_rdata_first", rd0, 32'h123477BB);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_valid_c%0d", k), {31'b0, rsp_valid}, 32'h1);
      chk($sformatf("bp_rdata_c%0d", k), rsp_rdata, 32'h123477BB);
      chk($sformatf("bp_req_ready_c%0d", k), {31'b0, req_ready}, 32'h0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("bp_back_idle", {31'b0, req_ready}, 32'h1);

    // Reset during WRITE of a byte store
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h19; req_wdata = 32'h00000055;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rstw_in_write_wen", {31'b0, mem_W_en}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("rstw_wen_async_drop", {31'b0, mem_W_en}, 32'h0);
    chk("rstw_no_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    @(posedge clk); #1;
    chk("rstw_no_rsp_valid_later", {31'b0, rsp_valid}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstw_req_ready", {31'b0, req_ready}, 32'h1);
    chk("rstw_word_unchanged", mem[6], refmem[6]);
    do_req(1'b0, 3'b010, 32'h18, 32'h0, rd, e, lat, wens);
    chk("rstw_readback", rd, refmem[6]);

    // Randomized requests against the reference model
    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      r  = $urandom_range(0, 9);
      if (r == 0) a = $urandom;
      else if (r == 1) a = 32'hFC0 + $urandom_range(0, 127);
      else a = $urandom_range(0, 127);
      wd = $urandom;
      do_req(we, f3, a, wd, rd, e, lat, wens);
      model(we, f3, a, wd, erd, ee, elat);
      chk($sformatf("rnd%0d_rdata", n), rd, erd);
      chk($sformatf("rnd%0d_err", n), {31'b0, e}, {31'b0, ee});
      chk($sformatf("rnd%0d_latency", n), 32'(lat), 32'(elat));
      chk($sformatf("rnd%0d_wen_pulses", n), 32'(wens), (we && !ee) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 1024; i++) begin
      if (mem[i] !== refmem[i]) chk($sformatf("final_mem%0d", i), mem[i], refmem[i]);
    end
    chk("final_mem5", mem[5], refmem[5]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
